interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

- Drives the processor's 2-bit `interruptSignal` input; this block is the initiator side of that interrupt interface.
- Rising edges on three external interrupt sources are latched as pending, the highest-priority unmasked one is chosen, and its code is held on `interruptSignal` until the processor acknowledges.
- The block then blocks further interrupts until the processor signals return-from-interrupt.
- Instantiated in the top-level controller beside instruction and data memory, driving the processor's interrupt input.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 15: cycles the block waits in ASSERT for `intAck` before withdrawing the request; legal range 1..255.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `src`  in  3  external interrupt sources, level inputs, rising edge is an event.
- `intMask`  in  3  1 = source blocked from arbitration; it is still latched as pending.
- `intAck`  in  1  processor accepted the current request; single-cycle pulse.
- `reti`  in  1  processor finished the handler; single-cycle pulse.
- `interruptSignal`  out  2  codes: 00 none, 01 source 0, 10 source 1, 11 source 2.
- `inService`  out  1  high while in IN_SERVICE.
- `pending`  out  3  latched, unserviced events.

## Operation
- Edge detect: `src_q` is `src` registered; `edge = src & ~src_q`. A pending bit is set on any clock edge where its `edge` bit is 1.
- Arbitration: among `pending & ~intMask`, source 0 has the highest priority and source 2 the lowest.
- States:
  - IDLE: if any unmasked bit is pending, register the winner's code onto `interruptSignal`, clear the timeout counter and go to ASSERT.
  - ASSERT: hold the code stable. No preemption, even if a higher-priority source becomes pending.
    - On `intAck`: clear the winner's pending bit, drive `interruptSignal` to 00 and go to IN_SERVICE.
    - Otherwise increment the counter. When it reaches `ACK_TIMEOUT`, drive 00, keep the pending bit and go to IDLE, which re-arbitrates on the next cycle.
  - IN_SERVICE: `interruptSignal` = 00 and `inService` = 1. Pending bits keep accumulating. On `reti`, go to IDLE.
- Ignored inputs: `intAck` outside ASSERT; `reti` outside IN_SERVICE.
- Merging: a new edge on a source that is already pending merges into one event.
- Set wins: if an edge arrives on the acknowledged source in the same cycle as `intAck`, its pending bit stays 1.
- Masking a source while it is being asserted does not withdraw the request; the mask takes effect at the next arbitration.
- The timeout counter is 8 bits and saturates; it is only meaningful in ASSERT.

## Timing
- Reset values: state IDLE, `interruptSignal` 00, `inService` 0, `pending` 000, `src_q` 000, counter 0. Reset mid-ASSERT or mid-IN_SERVICE drops the request and clears all pending events immediately (asynchronous).
- All outputs are registered.
- Latency without sync:
  - `src` first sampled high at edge k sets `pending` at edge k.
  - `interruptSignal` shows the code after edge k+1.
- `intAck` sampled at edge m: `interruptSignal` = 00 and `inService` = 1 after edge m.
- `reti` at edge r: IDLE after edge r. A pending source is asserted after edge r+1.
- Timeout: the code is visible for exactly `ACK_TIMEOUT` cycles, then 00 for 1 cycle, then is re-asserted if still the winner.

## Configuration
- `INTERRUPT_SYNC_EN` defined: each `src` bit passes through a 2-flop synchronizer (reset to 0) before edge detection, adding 2 cycles to event latency.
- Not defined: `src` feeds edge detection directly and must be synchronous to `clk`.

## Structure
Shared package:
- State enum: IDLE, ASSERT, IN_SERVICE.
- Code constants: INT_NONE = 2'b00, INT_SRC0 = 2'b01, INT_SRC1 = 2'b10, INT_SRC2 = 2'b11.
- Source count constant: NUM_SRC = 3.
- Counter width constant: 8.

Sub-module `int_edge_detect`:
- Per-bit optional synchronizer, `src_q` register and `edge` output.
- Arbitration and FSM stay in the top module.

## Test plan
- Reset released, src = 000 for 20 cycles -> `interruptSignal` 00, `pending` 000, `inService` 0 throughout.
- src[1] rises (k) -> `pending` 010 at k, `interruptSignal` 10 at k+1. `intAck` at k+3 -> 00, `inService` 1, `pending` 000. `reti` -> `inService` 0.
- src[2] and src[0] rise in the same cycle -> code 01 first. After ack and reti, code 11 appears 1 cycle after leaving IN_SERVICE.
- ACK_TIMEOUT = 4, src[0] rises, no ack -> code 01 for 4 cycles, 00 for 1, 01 again; `pending` stays 001.
- intMask = 001, src[0] rises -> `pending` 001, `interruptSignal` stays 00. Unmasking -> 01 next cycle.
- Reset asserted mid-ASSERT -> outputs return to reset values immediately.
- Edge on the acknowledged source in the ack cycle -> the bit remains pending and is served after `reti`.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller.
package interrupt_controller_pkg;

  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    IN_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] INT_NONE = 2'b00;
  localparam logic [1:0] INT_SRC0 = 2'b01;
  localparam logic [1:0] INT_SRC1 = 2'b10;
  localparam logic [1:0] INT_SRC2 = 2'b11;

  // Lowest-index request wins: isolate the least significant set bit.
  function automatic logic [NUM_SRC-1:0] pick_winner(input logic [NUM_SRC-1:0] req);
    pick_winner = req & (~req + NUM_SRC'(1));
  endfunction

  // Map a one-hot winner to its interrupt code.
  function automatic logic [1:0] code_of(input logic [NUM_SRC-1:0] oh);
    if (oh[0])      code_of = INT_SRC0;
    else if (oh[1]) code_of = INT_SRC1;
    else if (oh[2]) code_of = INT_SRC2;
    else            code_of = INT_NONE;
  endfunction

endpackage

// File: rtl/int_edge_detect.sv
// Rising-edge detector for the interrupt sources.
// INTERRUPT_SYNC_EN adds a 2-flop synchronizer per source ahead of detection.
module int_edge_detect
  import interrupt_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  output logic [NUM_SRC-1:0] src_edge_c
);

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_q;

`ifdef INTERRUPT_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;

  // Two-stage synchronizer for asynchronous sources.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  // Previous-cycle source level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) src_q <= '0;
    else        src_q <= src_s;
  end

  assign src_edge_c = src_s & ~src_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches source edges as pending, arbitrates by fixed
// priority (source 0 highest) and holds one request until acknowledged.
// Optional macro: INTERRUPT_SYNC_EN (synchronize src inside int_edge_detect).
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] intMask,
  input  logic               intAck,
  input  logic               reti,
  output logic [1:0]         interruptSignal,
  output logic               inService,
  output logic [NUM_SRC-1:0] pending
);

  localparam logic [CNT_W-1:0] ACK_TO  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_SRC-1:0] src_edge_c;
  state_e             state_q, state_d;
  logic [1:0]         int_sig_q, int_sig_d;
  logic               in_svc_q, in_svc_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] clr_c;
  logic [NUM_SRC-1:0] req_c;

  int_edge_detect u_edge (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .src_edge_c (src_edge_c)
  );

  assign req_c = pend_q & ~intMask;

  // Next-state, output and pending-bit logic; edges win over ack clears.
  always_comb begin
    state_d   = state_q;
    int_sig_d = int_sig_q;
    in_svc_d  = in_svc_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    clr_c     = '0;
    case (state_q)
      IDLE: begin
        if (|req_c) begin
          win_d     = pick_winner(req_c);
          int_sig_d = code_of(win_d);
          cnt_d     = '0;
          state_d   = ASSERT;
        end
      end
      ASSERT: begin
        if (intAck) begin
          clr_c     = win_q;
          int_sig_d = INT_NONE;
          in_svc_d  = 1'b1;
          state_d   = IN_SERVICE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (cnt_d == ACK_TO) begin
            int_sig_d = INT_NONE;
            state_d   = IDLE;
          end
        end
      end
      IN_SERVICE: begin
        if (reti) begin
          in_svc_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        int_sig_d = INT_NONE;
        in_svc_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
    pend_d = (pend_q & ~clr_c) | src_edge_c;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      int_sig_q <= INT_NONE;
      in_svc_q  <= 1'b0;
      pend_q    <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      int_sig_q <= int_sig_d;
      in_svc_q  <= in_svc_d;
      pend_q    <= pend_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
    end
  end

  assign interruptSignal = int_sig_q;
  assign inService       = in_svc_q;
  assign pending         = pend_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller (default build, ACK_TIMEOUT = 4).
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] src;
  logic [2:0] intMask;
  logic       intAck;
  logic       reti;
  logic [1:0] interruptSignal;
  logic       inService;
  logic [2:0] pending;

  int n_chk  = 0;
  int n_pass = 0;

  interrupt_controller #(.ACK_TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .src             (src),
    .intMask         (intMask),
    .intAck          (intAck),
    .reti            (reti),
    .interruptSignal (interruptSignal),
    .inService       (inService),
    .pending         (pending)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  initial begin
    reset = 1'b0; src = 3'b000; intMask = 3'b000; intAck = 1'b0; reti = 1'b0;
    repeat (3) tick();
    check("reset_sig", 8'(interruptSignal), 8'h0);
    check("reset_pend", 8'(pending), 8'h0);
    check("reset_insvc", 8'(inService), 8'h0);
    reset = 1'b1;

    // Quiet sources: nothing happens.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_quiet", {2'b00, interruptSignal, inService, pending}, 8'h00);
    end

    // Single source 1: pend at k, code at k+1, ack at k+3, reti.
    src = 3'b010;
    tick();
    check("s1_pend", 8'(pending), 8'h2);
    check("s1_sig_k", 8'(interruptSignal), 8'h0);
    tick();
    check("s1_sig_k1", 8'(interruptSignal), 8'h2);
    tick();
    check("s1_sig_hold", 8'(interruptSignal), 8'h2);
    pulse_ack();
    check("s1_ack_sig", 8'(interruptSignal), 8'h0);
    check("s1_ack_insvc", 8'(inService), 8'h1);
    check("s1_ack_pend", 8'(pending), 8'h0);
    pulse_reti();
    check("s1_reti_insvc", 8'(inService), 8'h0);
    tick();
    check("s1_after_sig", 8'(interruptSignal), 8'h0);
    src = 3'b000;
    tick();

    // Sources 0 and 2 together: 0 first, then 2 one cycle after reti.
    src = 3'b101;
    tick();
    check("pri_pend", 8'(pending), 8'h5);
    tick();
    check("pri_first", 8'(interruptSignal), 8'h1);
    pulse_ack();
    check("pri_ack_pend", 8'(pending), 8'h4);
    check("pri_ack_sig", 8'(interruptSignal), 8'h0);
    tick();
    check("pri_insvc_sig", 8'(interruptSignal), 8'h0);
    pulse_reti();
    check("pri_reti_sig", 8'(interruptSignal), 8'h0);
    check("pri_reti_insvc", 8'(inService), 8'h0);
    tick();
    check("pri_second", 8'(interruptSignal), 8'h3);
    pulse_ack();
    check("pri_ack2_pend", 8'(pending), 8'h0);
    pulse_reti();
    src = 3'b000;
    tick();

    // Timeout: code for 4 cycles, 00 for 1, then re-asserted.
    src = 3'b001;
    tick();
    tick();
    check("to_sig_c1", 8'(interruptSignal), 8'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_sig_hold", 8'(interruptSignal), 8'h1);
    end
    tick();
    check("to_sig_drop", 8'(interruptSignal), 8'h0);
    check("to_pend_kept", 8'(pending), 8'h1);
    tick();
    check("to_sig_reassert", 8'(interruptSignal), 8'h1);
    src = 3'b000;
    pulse_ack();
    check("to_ack_pend", 8'(pending), 8'h0);
    pulse_reti();
    tick();

    // Masked source is latched but not asserted; stray ack is ignored.
    intMask = 3'b001;
    src = 3'b001;
    tick();
    check("mask_pend", 8'(pending), 8'h1);
    tick();
    check("mask_sig", 8'(interruptSignal), 8'h0);
    pulse_ack();
    check("mask_ack_ign_pend", 8'(pending), 8'h1);
    check("mask_ack_ign_insvc", 8'(inService), 8'h0);
    intMask = 3'b000;
    tick();
    check("unmask_sig", 8'(interruptSignal), 8'h1);
    src = 3'b000;
    pulse_ack();
    pulse_reti();
    tick();

    // Edge on the acknowledged source during the ack cycle stays pending.
    src = 3'b010;
    tick();
    tick();
    check("sw_sig", 8'(interruptSignal), 8'h2);
    src = 3'b000;
    tick();
    src = 3'b010;
    pulse_ack();
    check("sw_pend", 8'(pending), 8'h2);
    check("sw_insvc", 8'(inService), 8'h1);
    pulse_reti();
    tick();
    check("sw_reserve", 8'(interruptSignal), 8'h2);
    pulse_ack();
    check("sw_ack2_pend", 8'(pending), 8'h0);
    pulse_reti();
    src = 3'b000;
    tick();

    // No preemption, then asynchronous reset mid-ASSERT.
    src = 3'b100;
    tick();
    tick();
    check("np_sig", 8'(interruptSignal), 8'h3);
    src = 3'b111;
    tick();
    check("np_pend", 8'(pending), 8'h7);
    tick();
    check("np_hold", 8'(interruptSignal), 8'h3);
    reset = 1'b0;
    #1;
    check("rst_async_sig", 8'(interruptSignal), 8'h0);
    check("rst_async_pend", 8'(pending), 8'h0);
    check("rst_async_insvc", 8'(inService), 8'h0);
    tick();
    reset = 1'b1;
    src = 3'b000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
